// File: rtl/h2_image_writer.sv
// Packs a narrow stream of 162 words into the 27 x 162-bit H2 image and commits it in one wide RAM write.
// Latency: wea one cycle after the final handshake, done one cycle after wea; s_ready only while collecting.
// Optional H2_FRAME_CHECK_EN: s_last must mark exactly the final word, otherwise err and abort without writing.
module h2_image_writer #(
    parameter int WORD_W = 32,
    parameter int ROW_W  = 162,
    parameter int ROWS   = 27,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       bank_addr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WORD_W-1:0]       s_data,
    input  logic                    s_last,
    output logic                    wea,
    output logic [ADDR_W-1:0]       addra,
    output logic [ROWS*ROW_W-1:0]   dina,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int WPR    = (ROW_W + WORD_W - 1) / WORD_W;
    localparam int LAST_W = ROW_W - (WPR - 1) * WORD_W;
    localparam int IMG_W  = ROWS * ROW_W;
    localparam int WC_W   = $clog2(WPR);
    localparam int RC_W   = $clog2(ROWS);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WPR - 1);
    localparam logic [RC_W-1:0] ROW_LAST  = RC_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, FIN} state_t;

    state_t             state_q, state_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [RC_W-1:0]    row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IMG_W-1:0]   image_q, image_d;
    logic               wea_q, wea_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               hs;
    logic               last_word;
    logic               final_word;
    int                 slot_lsb;

    assign s_ready    = (state_q == COLLECT);
    assign hs         = s_valid && s_ready;
    assign last_word  = (word_cnt_q == WORD_LAST);
    assign final_word = last_word && (row_cnt_q == ROW_LAST);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        addr_d     = addr_q;
        image_d    = image_q;
        wea_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        slot_lsb   = int'(row_cnt_q) * ROW_W + int'(word_cnt_q) * WORD_W;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COLLECT;
                    addr_d     = bank_addr;
                    word_cnt_d = '0;
                    row_cnt_d  = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            COLLECT: begin
                if (hs) begin
                    // The last word of a row only carries the row's leftover bits; the rest is dropped.
                    if (last_word) begin
                        image_d[slot_lsb +: LAST_W] = s_data[LAST_W-1:0];
                        word_cnt_d = '0;
                        row_cnt_d  = row_cnt_q + RC_W'(1);
                    end else begin
                        image_d[slot_lsb +: WORD_W] = s_data;
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
`ifdef H2_FRAME_CHECK_EN
                    if (s_last != final_word) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (final_word) begin
                        state_d = COMMIT;
                        wea_d   = 1'b1;
                    end
`else
                    if (final_word) begin
                        state_d = COMMIT;
                        wea_d   = 1'b1;
                    end
`endif
                end
            end
            COMMIT: begin
                state_d = FIN;
                done_d  = 1'b1;
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef H2_FRAME_CHECK_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            addr_q     <= '0;
            image_q    <= '0;
            wea_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            addr_q     <= addr_d;
            image_q    <= image_d;
            wea_q      <= wea_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wea   = wea_q;
    assign addra = addr_q;
    assign dina  = image_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_h2_image_writer.sv
// Directed bench for h2_image_writer: reset, full and gapped loads, mid-load reset, ignored starts, framing (with H2_FRAME_CHECK_EN).
module tb_h2_image_writer;
    localparam int WORD_W = 32;
    localparam int ROW_W  = 162;
    localparam int ROWS   = 27;
    localparam int ADDR_W = 8;
    localparam int IMG_W  = ROWS * ROW_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  bank_addr;
    logic               s_valid;
    logic               s_ready;
    logic [WORD_W-1:0]  s_data;
    logic               s_last;
    logic               wea;
    logic [ADDR_W-1:0]  addra;
    logic [IMG_W-1:0]   dina;
    logic               busy;
    logic               done;
    logic               err;

    int n_checks = 0;
    int n_pass   = 0;

    int ncyc = 0, hs_cnt = 0, last_hs = 0, wea_cnt = 0, wea_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [ADDR_W-1:0] wea_addr;
    logic [IMG_W-1:0]  wea_dat;

    h2_image_writer #(.WORD_W(WORD_W), .ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bank_addr(bank_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wea(wea), .addra(addra), .dina(dina), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge sees what the next posedge will sample.
    always @(negedge clk) begin
        ncyc++;
        if (s_valid && s_ready) begin
            hs_cnt++;
            last_hs = ncyc;
        end
        if (wea) begin
            wea_cnt++;
            wea_cyc  = ncyc;
            wea_addr = addra;
            wea_dat  = dina;
        end
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_of(input int r, input int k);
        return {14'h0, 5'(r), 3'(k), 10'h2A5};
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] row;
        logic [31:0]      w;
        row = '0;
        for (int k = 0; k < 5; k++) row[k*32 +: 32] = word_of(r, k);
        w = word_of(r, 5);
        row[161:160] = w[1:0];
        return row;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rows(input string tag, input logic [IMG_W-1:0] img);
        for (int r = 0; r < ROWS; r++)
            check_eq($sformatf("%s_row%0d", tag, r), 256'(img[r*ROW_W +: ROW_W]), 256'(exp_row(r)));
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start     = 1'b1;
        bank_addr = a;
        tick();
        start     = 1'b0;
    endtask

    task automatic stream(input string tag, input int n_words, input int last_idx,
                          input bit gaps, input bit ign);
        int idx    = 0;
        int budget = 0;
        bit tog    = 1'b1;
        bit p20    = 1'b0;
        bit p100   = 1'b0;
        bit hs;
        while (idx < n_words && budget < 3000) begin
            start = 1'b0;
            if (ign && idx == 20 && !p20) begin
                start = 1'b1; bank_addr = 8'hEE; p20 = 1'b1;
            end
            if (ign && idx == 100 && !p100) begin
                start = 1'b1; bank_addr = 8'hEE; p100 = 1'b1;
            end
            s_valid = gaps ? tog : 1'b1;
            tog     = ~tog;
            s_data  = word_of(idx / 6, idx % 6);
            s_last  = (idx == last_idx);
            hs      = s_valid && s_ready;
            tick();
            if (hs) idx++;
            budget++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_eq({tag, "_words"}, 256'(idx), 256'(n_words));
    endtask

    task automatic full_load(input string tag, input logic [ADDR_W-1:0] a, input bit gaps, input bit ign);
        int hs0 = hs_cnt;
        int w0  = wea_cnt;
        int d0  = done_cnt;
        do_start(a);
        check_eq({tag, "_busy_on"}, 256'(busy), 256'(1));
        check_eq({tag, "_err_clr"}, 256'(err), 256'(0));
        stream(tag, 162, 161, gaps, ign);
        repeat (4) tick();
        check_eq({tag, "_hs"},       256'(hs_cnt - hs0), 256'(162));
        check_eq({tag, "_wea_cnt"},  256'(wea_cnt - w0), 256'(1));
        check_eq({tag, "_wea_lat"},  256'(wea_cyc - last_hs), 256'(1));
        check_eq({tag, "_done_cnt"}, 256'(done_cnt - d0), 256'(1));
        check_eq({tag, "_done_lat"}, 256'(done_cyc - wea_cyc), 256'(1));
        check_eq({tag, "_wea_addr"}, 256'(wea_addr), 256'(a));
        check_eq({tag, "_addra"},    256'(addra), 256'(a));
        check_eq({tag, "_busy_off"}, 256'(busy), 256'(0));
        check_eq({tag, "_err"},      256'(err), 256'(0));
        check_rows(tag, wea_dat);
    endtask

    initial begin
        int w0;
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        bank_addr = 8'h5A;
        s_valid   = 1'b1;
        s_data    = 32'hDEADBEEF;
        s_last    = 1'b1;
        repeat (3) tick();
        check_eq("rst_wea",   256'(wea), 256'(0));
        check_eq("rst_addra", 256'(addra), 256'(0));
        check_eq("rst_dina",  256'(|dina), 256'(0));
        check_eq("rst_busy",  256'(busy), 256'(0));
        check_eq("rst_done",  256'(done), 256'(0));
        check_eq("rst_err",   256'(err), 256'(0));
        check_eq("rst_ready", 256'(s_ready), 256'(0));
        rst = 1'b0;
        repeat (3) tick();
        check_eq("idle_ready", 256'(s_ready), 256'(0));
        check_eq("idle_no_hs", 256'(hs_cnt), 256'(0));
        check_eq("idle_busy",  256'(busy), 256'(0));
        s_valid = 1'b0;
        s_last  = 1'b0;

        full_load("full", 8'h03, 1'b0, 1'b0);
        check_eq("full_r0w0",  256'(wea_dat[31:0]), 256'(32'h0000_02A5));
        check_eq("full_r0w1",  256'(wea_dat[63:32]), 256'(32'h0000_06A5));
        check_eq("full_r0w5",  256'(wea_dat[161:160]), 256'(2'b01));
        check_eq("full_r1w0",  256'(wea_dat[193:162]), 256'(32'h0000_22A5));
        check_eq("full_r26w0", 256'(wea_dat[26*162 +: 32]), 256'(32'h0003_42A5));
        check_eq("full_top",   256'(wea_dat[4373:4372]), 256'(2'b01));

        full_load("bp", 8'h05, 1'b1, 1'b0);

`ifdef H2_FRAME_CHECK_EN
        w0 = wea_cnt;
        d0 = done_cnt;
        do_start(8'h11);
        stream("frm_early", 11, 10, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("frm_early_err",   256'(err), 256'(1));
        check_eq("frm_early_busy",  256'(busy), 256'(0));
        check_eq("frm_early_ready", 256'(s_ready), 256'(0));
        check_eq("frm_early_wea",   256'(wea_cnt - w0), 256'(0));
        check_eq("frm_early_done",  256'(done_cnt - d0), 256'(0));
        full_load("frm_clean", 8'h12, 1'b0, 1'b0);
        w0 = wea_cnt;
        d0 = done_cnt;
        do_start(8'h13);
        stream("frm_late", 162, -1, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("frm_late_err",  256'(err), 256'(1));
        check_eq("frm_late_busy", 256'(busy), 256'(0));
        check_eq("frm_late_wea",  256'(wea_cnt - w0), 256'(0));
        check_eq("frm_late_done", 256'(done_cnt - d0), 256'(0));
`endif

        w0 = wea_cnt;
        d0 = done_cnt;
        do_start(8'h09);
        stream("rst_mid", 51, -1, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        check_eq("rst_mid_wea",   256'(wea_cnt - w0), 256'(0));
        check_eq("rst_mid_done",  256'(done_cnt - d0), 256'(0));
        check_eq("rst_mid_busy",  256'(busy), 256'(0));
        check_eq("rst_mid_addra", 256'(addra), 256'(0));
        check_eq("rst_mid_dina",  256'(|dina), 256'(0));
        check_eq("rst_mid_ready", 256'(s_ready), 256'(0));
        rst = 1'b0;
        tick();
        full_load("post_rst", 8'h07, 1'b0, 1'b0);

        full_load("ign", 8'h0A, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
